// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared core definitions: sequencer state encoding, register index width and
// forwarding-mux selects so the hazard and forwarding units agree on stage numbering.
package core_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_MEMW  = 2'd1,
        ST_FLUSH = 2'd2
    } ctrl_state_e;

    localparam int REG_IDX_W = 4;

    localparam logic [1:0] FWD_REGFILE = 2'd1;
    localparam logic [1:0] FWD_EX      = 2'd2;
    localparam logic [1:0] FWD_MEM     = 2'd3;

    // A source operand that is read and names the in-flight load destination.
    function automatic logic src_hazard(input logic                 used,
                                        input logic [REG_IDX_W-1:0] src,
                                        input logic [REG_IDX_W-1:0] dst,
                                        input logic                 r0_hw);
        return used && (src == dst) && !(r0_hw && (dst == '0));
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side hazard/control signal bundle between the datapath (master)
// and the hazard sequencer (slave).
interface pipe_hazard_ctrl_if
    import core_pkg::*;
#(
    parameter int unsigned CNT_W = 16
);
    logic [REG_IDX_W-1:0] RegReadIndex11;
    logic [REG_IDX_W-1:0] RegReadIndex21;
    logic                 ReadUsed11;
    logic                 ReadUsed21;
    logic [REG_IDX_W-1:0] RegWriteIndex2;
    logic                 RegWrite2;
    logic                 MemRead2;
    logic                 BranchTaken2;
    logic                 MemReq3;
    logic                 MemReady;
    logic                 PcWrite;
    logic                 IfIdWrite;
    logic                 IfIdFlush;
    logic                 IdExBubble;
    logic                 PipeFreeze;
    logic                 MemTimeout;
    logic [1:0]           CtrlState;
    logic [CNT_W-1:0]     StallCycles;
    logic [CNT_W-1:0]     FlushCount;

    modport master (
        output RegReadIndex11, RegReadIndex21, ReadUsed11, ReadUsed21,
               RegWriteIndex2, RegWrite2, MemRead2, BranchTaken2, MemReq3, MemReady,
        input  PcWrite, IfIdWrite, IfIdFlush, IdExBubble, PipeFreeze,
               MemTimeout, CtrlState, StallCycles, FlushCount
    );

    modport slave (
        input  RegReadIndex11, RegReadIndex21, ReadUsed11, ReadUsed21,
               RegWriteIndex2, RegWrite2, MemRead2, BranchTaken2, MemReq3, MemReady,
        output PcWrite, IfIdWrite, IfIdFlush, IdExBubble, PipeFreeze,
               MemTimeout, CtrlState, StallCycles, FlushCount
    );

endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);
    logic [W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (inc_i && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard sequencer: load-use stall, taken-branch flush, memory-wait freeze
// with optional timeout, plus saturating stall/flush counters.
module pipe_hazard_ctrl
    import core_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned MEM_TIMEOUT  = 255,
    parameter bit          R0_HARDWIRED = 1'b0,
    parameter int unsigned CNT_W        = 16
) (
    input logic               clk,
    input logic               rst_n,
    pipe_hazard_ctrl_if.slave hz
);
    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 2 : $clog2(MEM_TIMEOUT + 1);
    localparam int FL_W   = (FLUSH_CYCLES < 3) ? 1 : $clog2(FLUSH_CYCLES);
    localparam logic [WAIT_W-1:0] TO_VAL  = WAIT_W'(MEM_TIMEOUT);
    localparam logic [FL_W-1:0]   FL_INIT = FL_W'(FLUSH_CYCLES - 1);

    ctrl_state_e       state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [FL_W-1:0]   left_q, left_d;
    logic              to_q, to_d;

    logic pc_w, ifid_w, ifid_f, bubble, freeze, flush_inc;
    logic mem_wait, load_use, to_hit;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    assign mem_wait = hz.MemReq3 && !hz.MemReady;
    assign load_use = hz.MemRead2 && hz.RegWrite2 &&
        (src_hazard(hz.ReadUsed11, hz.RegReadIndex11, hz.RegWriteIndex2, R0_HARDWIRED) ||
         src_hazard(hz.ReadUsed21, hz.RegReadIndex21, hz.RegWriteIndex2, R0_HARDWIRED));
    assign to_hit   = (MEM_TIMEOUT != 0) && (wait_q == TO_VAL);

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        left_d    = left_q;
        to_d      = to_q;
        pc_w      = 1'b1;
        ifid_w    = 1'b1;
        ifid_f    = 1'b0;
        bubble    = 1'b0;
        freeze    = 1'b0;
        flush_inc = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (mem_wait) begin
                    {pc_w, ifid_w, freeze} = 3'b001;
                    state_d = ST_MEMW;
                    wait_d  = WAIT_W'(1);
                end else if (hz.BranchTaken2) begin
                    ifid_f    = 1'b1;
                    bubble    = 1'b1;
                    flush_inc = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = ST_FLUSH;
                        left_d  = FL_INIT;
                    end
                end else if (load_use) begin
                    {pc_w, ifid_w, bubble} = 3'b001;
                end
            end
            ST_MEMW: begin
                // Ready beats timeout; an interrupted flush resumes only on a clean ready.
                if (hz.MemReady) begin
                    wait_d  = '0;
                    state_d = (left_q != '0) ? ST_FLUSH : ST_RUN;
                end else if (to_hit) begin
                    to_d    = 1'b1;
                    wait_d  = '0;
                    left_d  = '0;
                    state_d = ST_RUN;
                end else begin
                    {pc_w, ifid_w, freeze} = 3'b001;
                    if (wait_q != '1) wait_d = wait_q + 1'b1;
                end
            end
            ST_FLUSH: begin
                if (mem_wait) begin
                    {pc_w, ifid_w, freeze} = 3'b001;
                    state_d = ST_MEMW;
                    wait_d  = WAIT_W'(1);
                end else begin
                    ifid_f = 1'b1;
                    left_d = left_q - 1'b1;
                    if (left_q == FL_W'(1)) state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
        // Idle control values while reset is held, independent of pipe inputs.
        if (!rst_n) begin
            {pc_w, ifid_w, ifid_f, bubble, freeze} = 5'b11000;
            flush_inc = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            wait_q  <= '0;
            left_q  <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            left_q  <= left_d;
            to_q    <= to_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (!pc_w),
        .count_o (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (flush_inc),
        .count_o (flush_cnt)
    );

    assign hz.PcWrite     = pc_w;
    assign hz.IfIdWrite   = ifid_w;
    assign hz.IfIdFlush   = ifid_f;
    assign hz.IdExBubble  = bubble;
    assign hz.PipeFreeze  = freeze;
    assign hz.MemTimeout  = to_q;
    assign hz.CtrlState   = state_q;
    assign hz.StallCycles = stall_cnt;
    assign hz.FlushCount  = flush_cnt;

endmodule
